change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 15, giving the maximum cycles a coin request may wait for i_hopper_ack (used only with CHANGE_TIMEOUT_EN).
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 i_vend  input  1  one-cycle strobe from the vending controller: soda dispensed, change valid.
REQ-005 i_change  input  3  change owed, in nickel units (0..7 = 0..35 cents); sampled only with i_vend.
REQ-006 i_hopper_ack  input  1  coin hopper acknowledge: requested coin has been ejected.
REQ-007 o_quarter  output  1  request eject of one quarter (5 units).
REQ-008 o_dime  output  1  request eject of one dime (2 units).
REQ-009 o_nickel  output  1  request eject of one nickel (1 unit).
REQ-010 o_busy  output  1  transaction in progress; i_vend ignored while high.
REQ-011 o_done  output  1  one-cycle pulse: transaction complete.
REQ-012 o_coins  output  3  count of coins ejected in the current or last transaction.
REQ-013 o_fault  output  1  hopper timeout flag (CHANGE_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-014 The FSM SHALL have states IDLE, REQ, GAP, DONE, plus FAULT when CHANGE_TIMEOUT_EN is defined.
REQ-015 IDLE: on an edge with i_vend=1, rem <= i_change and o_coins <= 0; next state is REQ if i_change!=0, otherwise DONE.
REQ-016 REQ: exactly one of o_quarter/o_dime/o_nickel SHALL be high, selected greedily from registered rem: quarter if rem>=5, else dime if rem>=2, else nickel.
REQ-017 The coin request outputs SHALL be decoded only from registered state and rem, and SHALL be low in every state except REQ.
REQ-018 REQ with i_hopper_ack=1: rem <= rem - coin value; o_coins <= o_coins+1; next state is GAP.
REQ-019 REQ with i_hopper_ack=0: the state and request SHALL hold unchanged.
REQ-020 GAP: all requests low for exactly one cycle; next state is REQ if rem!=0, else DONE.
REQ-021 DONE: o_done=1 for exactly one cycle; next state is IDLE.
REQ-022 i_hopper_ack SHALL be ignored outside REQ.
REQ-023 o_busy SHALL be 1 in REQ, GAP, DONE and FAULT, and 0 in IDLE.
REQ-024 i_vend SHALL be ignored in every state other than IDLE.
REQ-025 rem SHALL be 3 bits and SHALL never underflow, because greedy selection guarantees coin value <= rem.
REQ-026 Coin counts: 7 -> quarter, dime (2 coins); 6 -> quarter, nickel; 4 -> dime, dime; 3 -> dime, nickel; the maximum is 2 coins per transaction.
REQ-027 Latency from i_vend to the first request SHALL be 1 cycle.
REQ-028 Latency from i_vend to o_done SHALL be 1 cycle when i_change=0.

Reset
REQ-029 With i_rst_n=0 at an edge: state <= IDLE, rem <= 0, o_coins <= 0, o_fault <= 0; all requests, o_busy and o_done SHALL be 0 the following cycle.
REQ-030 Reset SHALL take priority over every other input, including mid-REQ; the pending request SHALL drop and the remaining change is lost.

Configuration
REQ-031 Macro CHANGE_TIMEOUT_EN defined: a wait counter SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-032 Macro CHANGE_TIMEOUT_EN defined: reaching TIMEOUT_CYC cycles SHALL set state <= FAULT and o_fault <= 1, with requests low.
REQ-033 Macro CHANGE_TIMEOUT_EN defined: FAULT SHALL hold with o_busy=1 until reset, and SHALL never assert o_done.
REQ-034 Macro CHANGE_TIMEOUT_EN undefined: there SHALL be no counter and no FAULT state, o_fault SHALL be constant 0, and REQ SHALL wait indefinitely.

Verification
REQ-035 i_vend=1, i_change=7, ack 2 cycles after each request -> o_quarter, then one GAP cycle, then o_dime, o_done pulse, o_coins=2.
REQ-036 i_vend=1, i_change=0 -> o_done=1 the next cycle, no request asserted, o_coins=0, o_busy high for 1 cycle.
REQ-037 i_change=4, ack tied high -> o_dime 1 cycle, GAP, o_dime 1 cycle, GAP, DONE; then a second i_vend during busy is ignored.
REQ-038 i_change=5, i_rst_n=0 during o_quarter -> all outputs 0 next cycle and state IDLE; a following i_vend with i_change=1 yields o_nickel.
REQ-039 CHANGE_TIMEOUT_EN defined, TIMEOUT_CYC=15, i_change=1, no ack -> o_nickel drops and o_fault=1 after 15 REQ cycles; o_busy stays 1 until reset.
REQ-040 Exhaustive sweep of i_change 0..7 with random ack delays 0..5 -> sum of ejected coin values equals i_change and o_coins matches the greedy count.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays out change owed (nickel units) as greedy quarter/dime/nickel requests to a coin hopper.
// Latency: first coin request 1 cycle after i_vend; o_done 1 cycle after i_vend when no change is owed.
// Backpressure: each request holds until i_hopper_ack; i_vend is ignored while o_busy is high.
// Optional feature macro CHANGE_TIMEOUT_EN: hopper wait timeout with a sticky FAULT state.

module change_dispenser #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_vend,
  input  logic [2:0] i_change,
  input  logic       i_hopper_ack,
  output logic       o_quarter,
  output logic       o_dime,
  output logic       o_nickel,
  output logic       o_busy,
  output logic       o_done,
  output logic [2:0] o_coins,
  output logic       o_fault
);

  // Coin values in nickel units.
  localparam logic [2:0] QUARTER_VAL = 3'd5;
  localparam logic [2:0] DIME_VAL    = 3'd2;
  localparam logic [2:0] NICKEL_VAL  = 3'd1;

`ifdef CHANGE_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  // Counter must be able to hold TIMEOUT_CYC-1 (the last no-ack cycle before faulting).
  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3
  } state_t;
`endif

  state_t     state, state_nxt;
  logic [2:0] rem, rem_nxt;
  logic [2:0] coins, coins_nxt;

  // Greedy selection from the registered remainder.
  logic       sel_quarter, sel_dime, sel_nickel;
  logic [2:0] coin_val;

`ifdef CHANGE_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              fault, fault_nxt;
`endif

  // Greedy coin choice: largest coin that still fits in the remainder.
  always_comb begin
    sel_quarter = 1'b0;
    sel_dime    = 1'b0;
    sel_nickel  = 1'b0;
    coin_val    = NICKEL_VAL;
    if (rem >= QUARTER_VAL) begin
      sel_quarter = 1'b1;
      coin_val    = QUARTER_VAL;
    end else if (rem >= DIME_VAL) begin
      sel_dime = 1'b1;
      coin_val = DIME_VAL;
    end else begin
      sel_nickel = 1'b1;
      coin_val   = NICKEL_VAL;
    end
  end

  // Next-state and datapath update; coin_val never exceeds rem so rem cannot wrap.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    coins_nxt = coins;
`ifdef CHANGE_TIMEOUT_EN
    // Held at zero outside REQ, so it is already clear on every entry to REQ.
    wait_nxt  = '0;
    fault_nxt = fault;
`endif
    case (state)
      S_IDLE: begin
        if (i_vend) begin
          rem_nxt   = i_change;
          coins_nxt = 3'd0;
          state_nxt = (i_change != 3'd0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (i_hopper_ack) begin
          rem_nxt   = rem - coin_val;
          coins_nxt = coins + 3'd1;
          state_nxt = S_GAP;
        end
`ifdef CHANGE_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_FAULT;
          fault_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
`endif
      end
      S_GAP: begin
        state_nxt = (rem != 3'd0) ? S_REQ : S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
`ifdef CHANGE_TIMEOUT_EN
      S_FAULT: begin
        // Only reset leaves FAULT.
        state_nxt = S_FAULT;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, remainder and coin count registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      rem   <= 3'd0;
      coins <= 3'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      coins <= coins_nxt;
    end
  end

`ifdef CHANGE_TIMEOUT_EN
  // Hopper wait counter and sticky fault flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      fault    <= fault_nxt;
    end
  end

  assign o_fault = fault;
`else
  assign o_fault = 1'b0;
`endif

  // Outputs decoded purely from registered state and remainder.
  always_comb begin
    o_quarter = (state == S_REQ) && sel_quarter;
    o_dime    = (state == S_REQ) && sel_dime;
    o_nickel  = (state == S_REQ) && sel_nickel;
    o_busy    = (state != S_IDLE);
    o_done    = (state == S_DONE);
    o_coins   = coins;
  end

  // Simulation-only sanity checks on parameterisation and request encoding.
  a_timeout_range: assert property (@(posedge i_clk) TIMEOUT_CYC >= 1);
  a_req_onehot:    assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    $onehot0({o_quarter, o_dime, o_nickel}));
  a_no_underflow:  assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    (state == S_REQ) |-> (coin_val <= rem));

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: vector table of change/ack-delay cases plus directed sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
// Timeout scenario checked when CHANGE_TIMEOUT_EN is defined, indefinite wait otherwise.

module tb_change_dispenser;

  logic       clk;
  logic       rst_n;
  logic       vend;
  logic [2:0] change;
  logic       ack;
  logic       quarter, dime, nickel, busy, done, fault;
  logic [2:0] coins;

  int n_checks = 0;
  int n_fail   = 0;

  change_dispenser #(.TIMEOUT_CYC(15)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vend      (vend),
    .i_change    (change),
    .i_hopper_ack(ack),
    .o_quarter   (quarter),
    .o_dime      (dime),
    .o_nickel    (nickel),
    .o_busy      (busy),
    .o_done      (done),
    .o_coins     (coins),
    .o_fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int change;
    int ack_delay;
    int exp_coins;
    int exp_q;
    int exp_d;
    int exp_n;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [7:0] obs();
    return {quarter, dime, nickel, busy, done, coins};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One full transaction: vend, answer each request after ack_delay cycles, tally coins until done.
  task automatic run_txn(input vec_t v);
    int  qn, dn, nn, sum, gaps, idle_cyc, wait_n, reqs;
    bit  seen;
    qn = 0; dn = 0; nn = 0; sum = 0; gaps = 0; idle_cyc = 0; wait_n = 0; seen = 0;
    @(negedge clk);
    vend   = 1'b1;
    change = 3'(v.change);
    @(negedge clk);
    vend = 1'b0;
    for (int cyc = 0; cyc < 80 && !seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      reqs = int'(quarter) + int'(dime) + int'(nickel);
      if (done) begin
        seen = 1;
        ack  = 1'b0;
        chk("coins_at_done", int'(coins), v.exp_coins);
        chk("busy_at_done", int'(busy), 1);
        chk("no_req_at_done", reqs, 0);
      end else if (reqs != 0) begin
        chk("req_onehot", reqs, 1);
        if (wait_n >= v.ack_delay) begin
          ack = 1'b1;
          wait_n = 0;
          if (quarter) begin qn++; sum += 5; end
          else if (dime) begin dn++; sum += 2; end
          else begin nn++; sum += 1; end
        end else begin
          ack = 1'b0;
          wait_n++;
        end
      end else if (busy) begin
        ack = 1'b0;
        gaps++;
      end else begin
        ack = 1'b0;
        idle_cyc++;
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("coin_sum", sum, v.change);
    chk("quarters", qn, v.exp_q);
    chk("dimes", dn, v.exp_d);
    chk("nickels", nn, v.exp_n);
    chk("gap_cycles", gaps, v.exp_coins);
    chk("idle_while_txn", idle_cyc, 0);
  endtask

  logic [7:0] trace4[6];
  int         cnt;

  initial begin
    // change, ack_delay, coins, quarters, dimes, nickels
    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 3, 1, 0, 0, 1};
    vecs[2] = '{2, 1, 1, 0, 1, 0};
    vecs[3] = '{3, 0, 2, 0, 1, 1};
    vecs[4] = '{4, 5, 2, 0, 2, 0};
    vecs[5] = '{5, 2, 1, 1, 0, 0};
    vecs[6] = '{6, 4, 2, 1, 0, 1};
    vecs[7] = '{7, 2, 2, 1, 1, 0};
    vecs[8] = '{7, 0, 2, 1, 1, 0};
    vecs[9] = '{3, 5, 2, 0, 1, 1};

    // change=4 with ack tied high: {q,d,n,busy,done,coins}
    trace4[0] = 8'b010_1_0_000;
    trace4[1] = 8'b000_1_0_001;
    trace4[2] = 8'b010_1_0_001;
    trace4[3] = 8'b000_1_0_010;
    trace4[4] = 8'b000_1_1_010;
    trace4[5] = 8'b000_0_0_010;

    rst_n = 1'b0; vend = 1'b0; change = 3'd0; ack = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(obs()), 0);
    chk("reset_fault", int'(fault), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", int'(obs()), 0);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Zero change: done next cycle, busy for exactly one cycle
    @(negedge clk);
    vend = 1'b1; change = 3'd0;
    @(negedge clk);
    vend = 1'b0;
    chk("zero_change_done", int'(obs()), 8'b000_1_1_000);
    @(negedge clk);
    chk("zero_change_after", int'(obs()), 8'b000_0_0_000);

    // change=4, ack tied high, second vend during busy ignored
    vend = 1'b1; change = 3'd4; ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ack_high_trace%0d", i), int'(obs()), int'(trace4[i]));
      vend   = (i == 0);
      change = 3'd7;
    end
    ack = 1'b0; vend = 1'b0;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      cnt += int'(busy);
    end
    chk("busy_after_ignored_vend", cnt, 0);

    // Reset while a quarter is requested, then a 1-nickel transaction
    vend = 1'b1; change = 3'd5;
    @(negedge clk);
    vend = 1'b0;
    chk("quarter_before_reset", int'(quarter), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("outputs_after_mid_reset", int'(obs()), 0);
    chk("fault_after_mid_reset", int'(fault), 0);
    rst_n = 1'b1;
    run_txn('{1, 0, 1, 0, 0, 1});

`ifdef CHANGE_TIMEOUT_EN
    // No ack: nickel request for 15 cycles, then sticky fault
    @(negedge clk);
    vend = 1'b1; change = 3'd1;
    @(negedge clk);
    vend = 1'b0;
    cnt = 0;
    while (nickel && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk("timeout_req_cycles", cnt, 15);
    chk("fault_set", int'(fault), 1);
    chk("fault_state_outputs", int'(obs()), 8'b000_1_0_000);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!busy || done || !fault || quarter || dime || nickel) cnt++;
    end
    chk("fault_holds", cnt, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("fault_cleared_by_reset", int'(fault), 0);
    chk("outputs_after_fault_reset", int'(obs()), 0);
    rst_n = 1'b1;
`else
    // No ack: request waits indefinitely, fault stays low
    @(negedge clk);
    vend = 1'b1; change = 3'd1;
    @(negedge clk);
    vend = 1'b0;
    cnt = 0;
    repeat (40) begin
      if (nickel && busy && !fault) cnt++;
      @(negedge clk);
    end
    chk("indefinite_wait", cnt, 40);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("late_ack_gap", int'(obs()), 8'b000_1_0_001);
    @(negedge clk);
    chk("late_ack_done", int'(obs()), 8'b000_1_1_001);
    chk("fault_never_set", int'(fault), 0);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
